dmem_responder: RTL

Data-memory responder for the five-stage RV64 pipeline. It is the slave end of the `data_sram_*` request interface that the execute stage drives. It accepts one access per request, applies byte-lane writes to an internal 64-bit-wide memory, and returns read data to the MEM1 stage. For slow memory it inserts wait states through a stall request to the pipeline stall controller; read latency is configurable.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: word/lane widths,
// latency limit, default base address and the FSM state encoding.
package dmem_pkg;

  localparam int DMEM_WORD_W = 64;
  localparam int DMEM_BE_W   = 8;
  localparam int LAT_MAX     = 8;
  // Wide enough for the largest counter load, LAT_MAX-2.
  localparam int CNT_W       = $clog2(LAT_MAX);

  localparam logic [63:0] DMEM_BASE_ADDR = 64'h8000_0000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // One captured access: lane enables, byte address and lane-aligned data.
  typedef struct packed {
    logic [DMEM_BE_W-1:0]   we;
    logic [63:0]            addr;
    logic [DMEM_WORD_W-1:0] wdata;
  } dmem_req_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 64-bit words with byte-lane write enables.
// An enabled access with all lanes clear is a read; the read register only
// updates on reads, so it holds the last word read across writes and idles.
// No reset: contents and the read register power up undefined.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [DMEM_BE_W-1:0]           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DMEM_WORD_W-1:0]         wdata,
  output logic [DMEM_WORD_W-1:0]         rdata
);

  logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane write or full-word read on the single port.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we == '0) begin
        rdata <= mem[addr];
      end else begin
        for (int i = 0; i < DMEM_BE_W; i++) begin
          if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the data_sram request interface.
// Accepts one access at a time, inserts wait states through mem_stall when
// LATENCY > 1, range-checks the address and returns registered read data.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no access in flight; en=1 issues (commits now if LATENCY=1)
// WAIT    | access captured; count down, commit when cnt reaches 0
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [63:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_sram_en,
  input  logic [DMEM_BE_W-1:0]   data_sram_we,
  input  logic [63:0]            data_sram_addr,
  input  logic [DMEM_WORD_W-1:0] data_sram_wdata,
  output logic [DMEM_WORD_W-1:0] data_sram_rdata,
  output logic                   data_sram_rvalid,
  output logic                   mem_stall,
  output logic                   acc_fault
);

  localparam int               AW       = $clog2(DEPTH_WORDS);
  localparam logic [63:0]      END_ADDR = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd8;
  localparam bit               SINGLE   = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  if ((LATENCY < 1) || (LATENCY > LAT_MAX)) begin : g_bad_latency
    $error("dmem_responder: LATENCY %0d outside 1..%0d", LATENCY, LAT_MAX);
  end

  if ((DEPTH_WORDS < 2) || !is_pow2(DEPTH_WORDS)) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS %0d is not a power of two >= 2", DEPTH_WORDS);
  end

  logic [0:0]             state_q;
  logic [CNT_W-1:0]       cnt_q;
  dmem_req_t              cap_q;
  dmem_req_t              cur_req;
  logic                   issue;
  logic                   commit;
  logic                   cur_read;
  logic                   cur_in_range;
  logic [AW-1:0]          cur_index;
  logic                   ram_en;
  logic [DMEM_WORD_W-1:0] ram_q;
  logic                   rvalid_q;
  logic                   fault_q;
  logic                   rd_zero_q;

  // The access being committed: live inputs in IDLE (LATENCY=1 path),
  // the captured copy in WAIT, where EX inputs are not looked at.
  always_comb begin
    cur_req = cap_q;
    if (state_q == ST_IDLE) begin
      cur_req.we    = data_sram_we;
      cur_req.addr  = data_sram_addr;
      cur_req.wdata = data_sram_wdata;
    end
  end

  assign issue        = (state_q == ST_IDLE) && data_sram_en;
  assign commit       = (issue && SINGLE) || ((state_q == ST_WAIT) && (cnt_q == '0));
  assign cur_read     = (cur_req.we == '0);
  assign cur_in_range = (cur_req.addr >= BASE_ADDR) && (cur_req.addr < END_ADDR);
  // addr[2:0] drops out here; lanes are chosen by we alone.
  assign cur_index    = AW'((cur_req.addr - BASE_ADDR) >> 3);
  // Out-of-range accesses never reach the array, so a faulting write is dropped.
  assign ram_en       = commit && cur_in_range;

  // Low in the commit cycle so the pipeline advances on the commit edge.
  assign mem_stall = (issue && !SINGLE) || ((state_q == ST_WAIT) && (cnt_q != '0));

  // FSM, wait counter and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else if (state_q == ST_IDLE) begin
      if (issue && !SINGLE) begin
        state_q       <= ST_WAIT;
        cnt_q         <= CNT_LOAD;
        cap_q.we      <= data_sram_we;
        cap_q.addr    <= data_sram_addr;
        cap_q.wdata   <= data_sram_wdata;
      end
    end else begin
      if (cnt_q == '0) begin
        state_q <= ST_IDLE;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur_req.we),
    .addr  (cur_index),
    .wdata (cur_req.wdata),
    .rdata (ram_q)
  );

  // Response pulses and the read-data mask. The array's read register is the
  // read-data register; rd_zero_q forces 0 after reset (array is not reset)
  // and after an out-of-range read, and only changes on a read commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q  <= 1'b0;
      fault_q   <= 1'b0;
      rd_zero_q <= 1'b1;
    end else begin
      rvalid_q <= commit && cur_read;
      fault_q  <= commit && !cur_in_range;
      if (commit && cur_read) begin
        rd_zero_q <= !cur_in_range;
      end
    end
  end

  assign data_sram_rdata  = rd_zero_q ? '0 : ram_q;
  assign data_sram_rvalid = rvalid_q;
  assign acc_fault        = fault_q;

endmodule
